pipe_stage_if: RTL
==================

# pipe_stage_if

Instruction-fetch stage of the five-stage pipelined CPU, sitting directly upstream of the decode stage. It owns the program counter, selects the next PC from the decode stage's `pcsource`, `bpc`, `jpc` and register-target outputs, and drives the IF/ID pipeline register (`dpc4`, `dinst`). It tolerates a multi-cycle instruction memory through an `imem_ready` handshake. It also preserves a resolved branch or jump target when the delay-slot fetch is still waiting on memory.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `NOP_INST`, 32'h0000_0000, bubble instruction written to `dinst` (sll $0,$0,0).

- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  one clock; reset is synchronous and active-high. Port name is kept for codebase consistency; a value of 1 resets the block.
- `pcsource`  in  2  next-PC select from decode: 00 = pc+4, 01 = `bpc`, 10 = `rpc`, 11 = `jpc`.
- `bpc`  in  32  branch target from decode.
- `jpc`  in  32  jump target from decode.
- `rpc`  in  32  jr target (forwarded rs value `da` from decode).
- `wpcir`  in  1  1 = PC and IF/ID may update; 0 = load-use stall, hold both.
- `imem_inst`  in  32  instruction word at `imem_addr`.
- `imem_ready`  in  1  `imem_inst` is valid this cycle.
- `imem_addr`  out  32  fetch address; combinational copy of `pc`.
- `pc`  out  32  current PC register.
- `dpc4`  out  32  IF/ID register: pc+4 of the latched instruction.
- `dinst`  out  32  IF/ID register: instruction to decode.
- `dvalid`  out  1  IF/ID register: 1 = real instruction, 0 = bubble.

## Operation
- `pc4 = pc + 32'd4`, modulo 2^32. 0xFFFF_FFFC wraps to 0.
- Redirect target `tgt` is selected by `pcsource`. Code 00 means no redirect.
- The block has two states: RUN and PEND. It has one 32-bit register `ptgt` that holds the pending target.
- Priority per cycle, highest first:
  1. `resetn`=1: `pc`=RESET_PC, `dpc4`=0, `dinst`=NOP_INST, `dvalid`=0, state RUN, `ptgt`=0.
  2. `wpcir`=0: `pc`, `dpc4`, `dinst`, `dvalid`, state and `ptgt` all hold. `pcsource` is ignored and `imem_inst` is discarded; the same address is fetched again.
  3. `imem_ready`=0: `pc` holds. IF/ID is loaded with a bubble: `dinst`=NOP_INST, `dvalid`=0, `dpc4`=pc4.
     - If state is RUN and `pcsource`≠00, then `ptgt`←`tgt` and state→PEND. A taken branch or jump is in decode while its delay slot is stalled in fetch.
  4. `imem_ready`=1: IF/ID ← {`pc4`, `imem_inst`}, `dvalid`=1. Next `pc` is chosen as follows:
     - state RUN, `pcsource`≠00: `pc`←`tgt`.
     - state RUN, `pcsource`=00: `pc`←`pc4`.
     - state PEND: `pc`←`ptgt`, state→RUN. `pcsource` is ignored in PEND, because decode holds a bubble.
- The delay-slot instruction is always fetched and issued. The block never flushes.
- `ptgt` keeps its value after leaving PEND and is only overwritten on the next entry to PEND.

## Timing
- Fetch-to-decode latency is 1 cycle when `imem_ready`=1. The instruction at `pc` is visible on `dinst` after the next rising edge.
- A redirect takes effect at the edge where the delay slot is accepted, so the target is fetched on the following cycle.
- `imem_addr` changes only on clock edges. Memory may take any number of cycles. `imem_inst` is sampled only in a cycle where `imem_ready`=1 and `wpcir`=1.
- A stall (`wpcir`=0) that coincides with `imem_ready`=1 discards the word. Memory must accept a refetch of the same address.
- Reset asserted while in PEND discards `ptgt`. The first fetch after reset release is from RESET_PC.
- Outputs are registered, except `imem_addr`.

## Test plan
- **Reset then steady fetch.** Assert `resetn`=1 for 2 cycles, then `imem_ready`=1, `wpcir`=1, `pcsource`=00.
  - Required: `pc` goes 0, 4, 8, 12.
  - Required: `dpc4` lags by one cycle with values 4, 8, 12, and `dvalid`=1 from the first post-reset edge.
- **Load-use stall.** At `pc`=0x10, hold `wpcir`=0 for 2 cycles.
  - Required: `pc`=0x10, `dinst` and `dpc4` unchanged, no redirect even with `pcsource`=01.
  - Required: resumes with `pc`=0x14.
- **Taken branch, memory ready.** At `pc`=0x20 (delay slot), drive `pcsource`=01, `bpc`=0x100.
  - Required: `dinst` = the word at 0x20, `dpc4`=0x24, `pc`=0x100 next cycle.
- **Branch while delay slot waits.** At `pc`=0x20, `pcsource`=11, `jpc`=0x400, `imem_ready`=0 for 3 cycles.
  - Required: bubbles with `dvalid`=0, state PEND, `pc`=0x20.
  - Required: when `imem_ready`=1, `dinst` = the word at 0x20, then `pc`=0x400. Later `pcsource` values during PEND are ignored.
- **jr path and wrap.** `pcsource`=10, `rpc`=0xFFFF_FFFC, memory ready.
  - Required: `pc`=0xFFFF_FFFC, then 0x0000_0000, and `dpc4`=0 for that instruction.
- **Reset during PEND.** Enter PEND with `ptgt`=0x400, assert `resetn`=1 for one cycle.
  - Required: `pc`=RESET_PC, and the first fetch after release does not go to 0x400.

Source files
------------

// File: rtl/pipe_stage_if.sv
// Instruction-fetch stage: owns the PC, picks the next PC from decode's redirect
// outputs, and drives the IF/ID register. A redirect whose delay slot is still
// waiting on memory is parked in ptgt and applied once that slot is accepted.
module pipe_stage_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,     // active-high synchronous reset despite the name
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic        wpcir,
  input  logic [31:0] imem_inst,
  input  logic        imem_ready,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] dinst,
  output logic        dvalid
);

  typedef enum logic [0:0] {StRun, StPend} state_t;

  state_t      state;
  logic [31:0] ptgt;
  logic [31:0] pc4;
  logic [31:0] tgt;
  logic        redirect;

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;
  assign redirect  = (pcsource != 2'b00);

  // Redirect target mux; code 00 is "no redirect" and falls through to pc4.
  always_comb begin
    tgt = pc4;
    unique case (pcsource)
      2'b00:   tgt = pc4;
      2'b01:   tgt = bpc;
      2'b10:   tgt = rpc;
      2'b11:   tgt = jpc;
      default: tgt = pc4;
    endcase
  end

  // PC, IF/ID register and pending-redirect FSM.
  always_ff @(posedge clk) begin
    if (resetn) begin
      pc     <= RESET_PC;
      dpc4   <= 32'd0;
      dinst  <= NOP_INST;
      dvalid <= 1'b0;
      state  <= StRun;
      ptgt   <= 32'd0;
    end else if (wpcir) begin
      if (!imem_ready) begin
        // Memory busy: issue a bubble and keep refetching the same address.
        dpc4   <= pc4;
        dinst  <= NOP_INST;
        dvalid <= 1'b0;
        if (state == StRun && redirect) begin
          // Branch in decode while its delay slot waits: remember where to go.
          ptgt  <= tgt;
          state <= StPend;
        end
      end else begin
        dpc4   <= pc4;
        dinst  <= imem_inst;
        dvalid <= 1'b1;
        if (state == StPend) begin
          // Decode holds a bubble here, so pcsource is meaningless.
          pc    <= ptgt;
          state <= StRun;
        end else if (redirect) begin
          pc <= tgt;
        end else begin
          pc <= pc4;
        end
      end
    end
  end

endmodule
